// File: rtl/mem_arbiter.sv
// Byte-serial memory arbiter: instruction fetch and load/store share one 8-bit RAM port.
// Define IO_STALL_EN to enable back-pressure from the IO sink on stores to addresses with [17:16] == 2'b11.
module mem_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        rollback,
  input  logic [31:0] IC_addr,
  input  logic        IC_addr_sgn,
  output logic [31:0] IC_val,
  output logic        IC_val_sgn,
  input  logic [31:0] LSB_addr,
  input  logic        LSB_sgn,
  input  logic        LSB_wr,
  input  logic [1:0]  LSB_len,
  input  logic [31:0] LSB_wdata,
  output logic [31:0] LSB_val,
  output logic        LSB_done,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);

  // Handshake: a requester raises *_sgn and holds it, with stable address and
  // data, until the matching one-cycle pulse (IC_val_sgn or LSB_done) is seen.
  typedef enum logic [1:0] {IDLE, IFETCH, LOAD, STORE} state_t;

  state_t      state;
  logic [2:0]  cnt;
  logic [2:0]  last;
  logic [31:0] rd_buf;
  logic [31:0] st_data;
  logic        wr_q;
  logic        io_block_req;
  logic        io_stall;
  logic        accept_ok;
  logic        lsb_go;

`ifdef IO_STALL_EN
  assign io_block_req = io_buffer_full && LSB_wr && (LSB_addr[17:16] == 2'b11);
  assign io_stall     = io_buffer_full && (state == STORE) && (mem_a[17:16] == 2'b11);
`else
  logic unused_io;
  assign unused_io    = io_buffer_full;
  assign io_block_req = 1'b0;
  assign io_stall     = 1'b0;
`endif

  // The requester still holds its request during the pulse cycle, so block re-acceptance there.
  assign accept_ok = !IC_val_sgn && !LSB_done && !rollback;
  assign lsb_go    = LSB_sgn && !io_block_req;

  // The RAM write strobe is gated so a frozen or stalled byte is written exactly once.
  assign mem_wr = wr_q && rdy && !io_stall;

  function automatic logic [2:0] len_to_last(input logic [1:0] len);
    case (len)
      2'b00:   len_to_last = 3'd0;
      2'b01:   len_to_last = 3'd1;
      default: len_to_last = 3'd3;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 3'd0;
      last       <= 3'd0;
      rd_buf     <= 32'd0;
      st_data    <= 32'd0;
      wr_q       <= 1'b0;
      mem_a      <= 32'd0;
      mem_dout   <= 8'd0;
      IC_val     <= 32'd0;
      IC_val_sgn <= 1'b0;
      LSB_val    <= 32'd0;
      LSB_done   <= 1'b0;
    end else if (rdy) begin
      IC_val_sgn <= 1'b0;
      LSB_done   <= 1'b0;
      case (state)
        IDLE: begin
          if (accept_ok) begin
            if (lsb_go) begin
              mem_a <= LSB_addr;
              cnt   <= 3'd0;
              last  <= len_to_last(LSB_len);
              if (LSB_wr) begin
                state    <= STORE;
                wr_q     <= 1'b1;
                mem_dout <= LSB_wdata[7:0];
                st_data  <= LSB_wdata;
              end else begin
                state  <= LOAD;
                rd_buf <= 32'd0;
              end
            end else if (IC_addr_sgn) begin
              mem_a  <= IC_addr;
              cnt    <= 3'd0;
              last   <= 3'd3;
              state  <= IFETCH;
              rd_buf <= 32'd0;
            end
          end
        end
        IFETCH, LOAD: begin
          if (rollback) begin
            state <= IDLE;
          end else if (cnt > last) begin
            // Every byte is captured; publish the assembled word.
            state <= IDLE;
            if (state == IFETCH) begin
              IC_val     <= rd_buf;
              IC_val_sgn <= 1'b1;
            end else begin
              LSB_val  <= rd_buf;
              LSB_done <= 1'b1;
            end
          end else begin
            rd_buf[{cnt[1:0], 3'b000} +: 8] <= mem_din;
            cnt <= cnt + 3'd1;
            if (cnt != last) mem_a <= mem_a + 32'd1;
          end
        end
        STORE: begin
          if (!io_stall) begin
            if (cnt == last) begin
              wr_q     <= 1'b0;
              state    <= IDLE;
              LSB_done <= 1'b1;
            end else begin
              cnt      <= cnt + 3'd1;
              mem_a    <= mem_a + 32'd1;
              mem_dout <= st_data[15:8];
              st_data  <= {8'd0, st_data[31:8]};
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized bench for mem_arbiter against a byte-array memory reference.
// Honors IO_STALL_EN when the same macro is defined for the build.
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst, rdy, rollback;
  logic [31:0] IC_addr;
  logic        IC_addr_sgn;
  logic [31:0] IC_val;
  logic        IC_val_sgn;
  logic [31:0] LSB_addr;
  logic        LSB_sgn, LSB_wr;
  logic [1:0]  LSB_len;
  logic [31:0] LSB_wdata;
  logic [31:0] LSB_val;
  logic        LSB_done;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;

  logic [7:0]  ram [0:65535];
  logic [7:0]  ref_mem [0:65535];
  logic [39:0] exp_q[$];
  logic [39:0] act_q[$];
  int checks = 0;
  int errors = 0;

  int r_ic_edge, r_lsb_edge, r_ic_cnt, r_lsb_cnt;
  logic [31:0] r_ic_val, r_lsb_val;

`ifdef IO_STALL_EN
  localparam bit IO_ON = 1'b1;
`else
  localparam bit IO_ON = 1'b0;
`endif

  mem_arbiter dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
    .IC_addr(IC_addr), .IC_addr_sgn(IC_addr_sgn), .IC_val(IC_val), .IC_val_sgn(IC_val_sgn),
    .LSB_addr(LSB_addr), .LSB_sgn(LSB_sgn), .LSB_wr(LSB_wr), .LSB_len(LSB_len),
    .LSB_wdata(LSB_wdata), .LSB_val(LSB_val), .LSB_done(LSB_done),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  // Clock and RAM: combinational read, write sampled on the rising edge.
  always #5 clk = ~clk;
  assign mem_din = ram[mem_a[15:0]];
  always @(posedge clk) begin
    if (mem_wr) begin
      ram[mem_a[15:0]] <= mem_dout;
      act_q.push_back({mem_a, mem_dout});
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int n_of(input logic [1:0] len);
    return (len == 2'b00) ? 1 : (len == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] addr, input int n);
    logic [31:0] v;
    v = 32'd0;
    for (int k = 0; k < n; k++) v = v | (32'(ref_mem[16'(addr + 32'(k))]) << (8 * k));
    return v;
  endfunction

  task automatic model_store(input logic [31:0] addr, input logic [1:0] len, input logic [31:0] wd);
    logic [7:0] b;
    for (int k = 0; k < n_of(len); k++) begin
      b = 8'(wd >> (8 * k));
      ref_mem[16'(addr + 32'(k))] = b;
      exp_q.push_back({addr + 32'(k), b});
    end
  endtask

  // Each edge where rdy is low, at or before the undisturbed pulse edge, delays it by one.
  function automatic int exp_edge(input int base, input int rs, input int rl);
    return (rl > 0 && rs >= 0 && rs <= base) ? base + rl : base;
  endfunction

  task automatic check_writes(input string tag);
    chk({tag, "_wr_count"}, 64'(act_q.size()), 64'(exp_q.size()));
    while (exp_q.size() > 0 && act_q.size() > 0)
      chk({tag, "_wr_entry"}, 64'(act_q.pop_front()), 64'(exp_q.pop_front()));
    exp_q.delete();
    act_q.delete();
  endtask

  // Edge 0 is the first rising edge after the call; windows are given in edge numbers.
  task automatic run(input bit f_en, input logic [31:0] f_addr,
                     input bit l_en, input bit l_wr, input logic [31:0] l_addr,
                     input logic [1:0] l_len, input logic [31:0] l_wd,
                     input int rb_edge, input bit rb_drop,
                     input int rs, input int rl, input int fs, input int fl, input int window);
    bit ic_prev, lsb_prev;
    ic_prev = 1'b0; lsb_prev = 1'b0;
    r_ic_edge = -1; r_lsb_edge = -1; r_ic_cnt = 0; r_lsb_cnt = 0;
    IC_addr = f_addr; IC_addr_sgn = f_en;
    LSB_addr = l_addr; LSB_sgn = l_en; LSB_wr = l_wr; LSB_len = l_len; LSB_wdata = l_wd;
    for (int e = 0; e < window; e++) begin
      rollback = (e == rb_edge);
      rdy = !(e >= rs && e < rs + rl);
      io_buffer_full = (e >= fs && e < fs + fl);
      @(posedge clk); #1;
      if (e == rb_edge && rb_drop) begin
        IC_addr_sgn = 1'b0;
        if (!l_wr) LSB_sgn = 1'b0;
      end
      if (IC_val_sgn && !ic_prev) begin
        r_ic_cnt++;
        if (r_ic_edge < 0) begin r_ic_edge = e; r_ic_val = IC_val; end
        IC_addr_sgn = 1'b0;
      end
      if (LSB_done && !lsb_prev) begin
        r_lsb_cnt++;
        if (r_lsb_edge < 0) begin r_lsb_edge = e; r_lsb_val = LSB_val; end
        LSB_sgn = 1'b0;
      end
      ic_prev = IC_val_sgn;
      lsb_prev = LSB_done;
    end
    rollback = 1'b0; rdy = 1'b1; io_buffer_full = 1'b0;
    IC_addr_sgn = 1'b0; LSB_sgn = 1'b0;
  endtask

  initial begin
    int kind, rs, rl, n, seen;
    logic [31:0] a, wd, ev;
    logic [1:0] ln;
    logic [7:0] b;

    rst = 1'b1; rdy = 1'b1; rollback = 1'b0; io_buffer_full = 1'b0;
    IC_addr = 32'd0; IC_addr_sgn = 1'b0;
    LSB_addr = 32'd0; LSB_sgn = 1'b0; LSB_wr = 1'b0; LSB_len = 2'b00; LSB_wdata = 32'd0;
    for (int i = 0; i < 65536; i++) begin
      b = 8'($urandom);
      if (i == 32'h100) b = 8'h13;
      if (i == 32'h101) b = 8'h05;
      if (i == 32'h102 || i == 32'h103) b = 8'h00;
      if (i == 32'h104) b = 8'hA5;
      ram[i] <= b;
      ref_mem[i] = b;
    end

    // Reset values, before any clock edge
    #1;
    chk("rst_ic_val_sgn", IC_val_sgn, 0);
    chk("rst_lsb_done", LSB_done, 0);
    chk("rst_mem_wr", mem_wr, 0);
    chk("rst_ic_val", IC_val, 0);
    chk("rst_lsb_val", LSB_val, 0);
    chk("rst_mem_a", mem_a, 0);
    chk("rst_mem_dout", mem_dout, 0);
    #12 rst = 1'b0;

    // Basic 4-byte fetch
    run(1, 32'h100, 0, 0, 0, 2'b00, 0, -1, 0, -1, 0, -1, 0, 12);
    chk("fetch_edge", r_ic_edge, 5);
    chk("fetch_val", r_ic_val, 32'h0000_0513);
    chk("fetch_cnt", r_ic_cnt, 1);

    // Simultaneous load and fetch: load first, fetch after the pulse cycle
    run(1, 32'h100, 1, 0, 32'h104, 2'b00, 0, -1, 0, -1, 0, -1, 0, 14);
    chk("simul_lsb_edge", r_lsb_edge, 2);
    chk("simul_lsb_val", r_lsb_val, 32'h0000_00A5);
    chk("simul_ic_edge", r_ic_edge, 9);
    chk("simul_ic_val", r_ic_val, 32'h0000_0513);

    // Word store
    model_store(32'h200, 2'b10, 32'hDEAD_BEEF);
    run(0, 0, 1, 1, 32'h200, 2'b10, 32'hDEAD_BEEF, -1, 0, -1, 0, -1, 0, 10);
    chk("store_edge", r_lsb_edge, 4);
    check_writes("store");
    chk("lsb_val_hold", LSB_val, 32'h0000_00A5);
    chk("ic_val_hold", IC_val, 32'h0000_0513);

    // Rollback aborting a fetch whose request is withdrawn
    run(1, 32'h100, 0, 0, 0, 2'b00, 0, 3, 1, -1, 0, -1, 0, 12);
    chk("rb_drop_cnt", r_ic_cnt, 0);
    // Rollback with the request still held: IDLE at edge 3, re-accepted at edge 4
    run(1, 32'h100, 0, 0, 0, 2'b00, 0, 3, 0, -1, 0, -1, 0, 14);
    chk("rb_held_edge", r_ic_edge, 9);
    chk("rb_held_cnt", r_ic_cnt, 1);
    // Rollback in IDLE delays acceptance by one edge
    run(1, 32'h100, 0, 0, 0, 2'b00, 0, 0, 0, -1, 0, -1, 0, 12);
    chk("rb_idle_edge", r_ic_edge, 6);
    // Rollback during a store is ignored
    model_store(32'h300, 2'b10, 32'h1234_5678);
    run(0, 0, 1, 1, 32'h300, 2'b10, 32'h1234_5678, 2, 1, -1, 0, -1, 0, 10);
    chk("rb_store_edge", r_lsb_edge, 4);
    check_writes("rb_store");

    // rdy low for three edges mid-fetch
    run(1, 32'h100, 0, 0, 0, 2'b00, 0, -1, 0, 2, 3, -1, 0, 14);
    chk("rdy_edge", r_ic_edge, 8);
    chk("rdy_val", r_ic_val, 32'h0000_0513);

    // Asynchronous reset in the middle of a fetch
    IC_addr = 32'h100; IC_addr_sgn = 1'b1;
    @(posedge clk); @(posedge clk); #2;
    rst = 1'b1; #1;
    chk("midrst_ic_val", IC_val, 0);
    chk("midrst_lsb_val", LSB_val, 0);
    chk("midrst_mem_a", mem_a, 0);
    IC_addr_sgn = 1'b0; #1 rst = 1'b0;
    seen = 0;
    repeat (8) begin @(posedge clk); #1; if (IC_val_sgn) seen++; end
    chk("midrst_no_pulse", seen, 0);

    // IO back-pressure at acceptance, then mid-store
    model_store(32'h0003_0000, 2'b00, 32'h0000_005A);
    run(0, 0, 1, 1, 32'h0003_0000, 2'b00, 32'h0000_005A, -1, 0, -1, 0, 0, 4, 10);
    chk("io_accept_edge", r_lsb_edge, IO_ON ? 5 : 1);
    check_writes("io_accept");
    model_store(32'h0003_FFF0, 2'b10, 32'hCAFE_F00D);
    run(0, 0, 1, 1, 32'h0003_FFF0, 2'b10, 32'hCAFE_F00D, -1, 0, -1, 0, 2, 2, 12);
    chk("io_mid_edge", r_lsb_edge, IO_ON ? 6 : 4);
    check_writes("io_mid");

    // Randomized transfers with random rdy windows
    for (int it = 0; it < 24; it++) begin
      kind = $urandom_range(0, 2);
      rs = $urandom_range(0, 6);
      rl = $urandom_range(0, 3);
      ln = 2'($urandom_range(0, 2));
      n = n_of(ln);
      a = 32'($urandom_range(0, 65535));
      wd = $urandom;
      if (kind == 0) begin
        a = {a[31:2], 2'b00};
        ev = model_read(a, 4);
        run(1, a, 0, 0, 0, 2'b00, 0, -1, 0, rs, rl, -1, 0, 16);
        chk("rnd_fetch_edge", r_ic_edge, exp_edge(5, rs, rl));
        chk("rnd_fetch_val", r_ic_val, ev);
        chk("rnd_fetch_cnt", r_ic_cnt, 1);
      end else if (kind == 1) begin
        ev = model_read(a, n);
        run(0, 0, 1, 0, a, ln, 0, -1, 0, rs, rl, -1, 0, 16);
        chk("rnd_load_edge", r_lsb_edge, exp_edge(n + 1, rs, rl));
        chk("rnd_load_val", r_lsb_val, ev);
        chk("rnd_load_cnt", r_lsb_cnt, 1);
      end else begin
        model_store(a, ln, wd);
        run(0, 0, 1, 1, a, ln, wd, -1, 0, rs, rl, -1, 0, 16);
        chk("rnd_store_edge", r_lsb_edge, exp_edge(n, rs, rl));
        check_writes("rnd_store");
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
